// File: rtl/router_fsm_ctrl_if.sv
// Handshake and status bundle between the 1x3 router control FSM and its neighbours.
// master = surrounding router logic (drives inputs), slave = the control FSM.
interface router_fsm_ctrl_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_packet_valid;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;
  logic [2:0] state_o;
  logic       timeout;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_packet_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, state_o, timeout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_packet_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, state_o, timeout
  );
endinterface

// File: rtl/router_fsm_ctrl.sv
// Control FSM for the 1x3 router: header decode, payload/parity sequencing, backpressure.
// Define ROUTER_FSM_WATCHDOG_EN to abort WAIT_TILL_EMPTY after WAIT_LIMIT cycles.
module router_fsm_ctrl #(
  parameter int unsigned WAIT_LIMIT   = 30,
  parameter logic [1:0]  ADDR_INVALID = 2'b11
) (
  input logic               clock,
  input logic               resetn,
  router_fsm_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    StDa  = 3'd0,
    StLfd = 3'd1,
    StLd  = 3'd2,
    StWte = 3'd3,
    StFfs = 3'd4,
    StLaf = 3'd5,
    StLp  = 3'd6,
    StCpe = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [1:0] addr_chk;
  logic       addr_ok;
  logic       empty_sel;
  logic       soft_sel;
  logic       timeout_d;

  assign addr_ok  = (bus.data_in != ADDR_INVALID);
  // While decoding, the header on data_in has not been latched yet.
  assign addr_chk = (state_q == StDa) ? bus.data_in : addr_q;

  always_comb begin
    empty_sel = 1'b0;
    soft_sel  = 1'b0;
    case (addr_chk)
      2'd0:    empty_sel = bus.fifo_empty_0;
      2'd1:    empty_sel = bus.fifo_empty_1;
      2'd2:    empty_sel = bus.fifo_empty_2;
      default: empty_sel = 1'b0;
    endcase
    case (addr_q)
      2'd0:    soft_sel = bus.soft_reset_0;
      2'd1:    soft_sel = bus.soft_reset_1;
      2'd2:    soft_sel = bus.soft_reset_2;
      default: soft_sel = 1'b0;
    endcase
  end

`ifdef ROUTER_FSM_WATCHDOG_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q;
  logic        wd_expired;

  assign cnt_d      = (state_q == StWte) ? cnt_q + 16'd1 : 16'd0;
  assign wd_expired = (cnt_q == 16'(WAIT_LIMIT - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  logic unused_wait_limit;
  assign unused_wait_limit = ^WAIT_LIMIT;
  assign bus.timeout       = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    timeout_d = 1'b0;
    if (state_q == StDa && bus.pkt_valid && addr_ok) addr_d = bus.data_in;
    unique case (state_q)
      StDa:  if (bus.pkt_valid && addr_ok) state_d = empty_sel ? StLfd : StWte;
      StLfd: state_d = StLd;
      StLd: begin
        if (bus.fifo_full)       state_d = StFfs;
        else if (!bus.pkt_valid) state_d = StLp;
      end
      StFfs: if (!bus.fifo_full) state_d = StLaf;
      StLaf: begin
        if (bus.parity_done)           state_d = StDa;
        else if (bus.low_packet_valid) state_d = StLp;
        else                           state_d = StLd;
      end
      StLp:  state_d = StCpe;
      StCpe: state_d = bus.fifo_full ? StFfs : StDa;
      StWte: begin
        if (empty_sel) state_d = StLfd;
`ifdef ROUTER_FSM_WATCHDOG_EN
        else if (wd_expired) begin
          state_d   = StDa;
          timeout_d = 1'b1;
        end
`endif
      end
      default: state_d = StDa;
    endcase
    // Destination soft reset overrides every transition once a packet is in flight.
    if (state_q != StDa && soft_sel) begin
      state_d   = StDa;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StDa;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    bus.detect_add    = (state_q == StDa);
    bus.lfd_state     = (state_q == StLfd);
    bus.ld_state      = (state_q == StLd);
    bus.laf_state     = (state_q == StLaf);
    bus.full_state    = (state_q == StFfs);
    bus.rst_int_reg   = (state_q == StCpe);
    bus.write_enb_reg = (state_q == StLd) || (state_q == StLaf) || (state_q == StLp);
    bus.busy          = !((state_q == StDa) || (state_q == StLd));
    bus.state_o       = state_q;
  end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Randomized self-checking bench for router_fsm_ctrl with a behavioural reference model.
module tb_router_fsm_ctrl;
  localparam int unsigned WaitLimit = 4;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cmp_en   = 1'b0;

  router_fsm_ctrl_if bus_if ();

  router_fsm_ctrl #(
    .WAIT_LIMIT  (WaitLimit),
    .ADDR_INVALID(2'b11)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  // Reference model: state numbers as listed in the state table, outputs from bit masks.
  int m_state   = 0;
  int m_addr    = 0;
  int m_wte     = 0;  // WTE cycles already spent
  bit m_timeout = 1'b0;
  localparam bit [7:0] BusyMask = 8'b1111_1010;
  localparam bit [7:0] WenMask  = 8'b0110_0100;

  function automatic bit empty_of(int a);
    bit [2:0] e;
    e = {bus_if.fifo_empty_2, bus_if.fifo_empty_1, bus_if.fifo_empty_0};
    return (a < 3) ? e[a] : 1'b0;
  endfunction

  function automatic bit soft_of(int a);
    bit [2:0] s;
    s = {bus_if.soft_reset_2, bus_if.soft_reset_1, bus_if.soft_reset_0};
    return (a < 3) ? s[a] : 1'b0;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_state = 0; m_addr = 0; m_wte = 0; m_timeout = 1'b0;
    end else begin
      int  nxt;
      bit  to;
      bit  pv;
      int  din;
      bit  e_sel;
      pv    = bus_if.pkt_valid;
      din   = int'(bus_if.data_in);
      e_sel = (m_state == 0) ? empty_of(din) : empty_of(m_addr);
      nxt   = m_state;
      to    = 1'b0;
      if (m_state != 0 && soft_of(m_addr)) nxt = 0;
      else if (m_state == 0) begin
        if (pv && din != 3) nxt = e_sel ? 1 : 3;
      end else if (m_state == 1) nxt = 2;
      else if (m_state == 2) nxt = bus_if.fifo_full ? 4 : (!pv ? 6 : 2);
      else if (m_state == 4) nxt = bus_if.fifo_full ? 4 : 5;
      else if (m_state == 5) nxt = bus_if.parity_done ? 0 : (bus_if.low_packet_valid ? 6 : 2);
      else if (m_state == 6) nxt = 7;
      else if (m_state == 7) nxt = bus_if.fifo_full ? 4 : 0;
      else if (m_state == 3) begin
        if (e_sel) nxt = 1;
`ifdef ROUTER_FSM_WATCHDOG_EN
        else if (m_wte == int'(WaitLimit) - 1) begin nxt = 0; to = 1'b1; end
`endif
      end
      if (m_state == 0 && pv && din != 3) m_addr = din;
      m_wte     = (m_state == 3) ? m_wte + 1 : 0;
      m_state   = nxt;
      m_timeout = to;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      check("state_o",       int'(bus_if.state_o),       m_state);
      check("detect_add",    int'(bus_if.detect_add),    int'(m_state == 0));
      check("lfd_state",     int'(bus_if.lfd_state),     int'(m_state == 1));
      check("ld_state",      int'(bus_if.ld_state),      int'(m_state == 2));
      check("full_state",    int'(bus_if.full_state),    int'(m_state == 4));
      check("laf_state",     int'(bus_if.laf_state),     int'(m_state == 5));
      check("rst_int_reg",   int'(bus_if.rst_int_reg),   int'(m_state == 7));
      check("busy",          int'(bus_if.busy),          int'(BusyMask[m_state]));
      check("write_enb_reg", int'(bus_if.write_enb_reg), int'(WenMask[m_state]));
      check("timeout",       int'(bus_if.timeout),       int'(m_timeout));
    end
  end

  task automatic drive(input bit pv, input bit [1:0] din, input bit full, input bit [2:0] emp,
                       input bit [2:0] sft, input bit pd, input bit lpv);
    bus_if.pkt_valid        = pv;
    bus_if.data_in          = din;
    bus_if.fifo_full        = full;
    bus_if.fifo_empty_0     = emp[0];
    bus_if.fifo_empty_1     = emp[1];
    bus_if.fifo_empty_2     = emp[2];
    bus_if.soft_reset_0     = sft[0];
    bus_if.soft_reset_1     = sft[1];
    bus_if.soft_reset_2     = sft[2];
    bus_if.parity_done      = pd;
    bus_if.low_packet_valid = lpv;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
  endtask

  // Advance one clock and pin both DUT and model to a hand-derived state.
  task automatic step(input string name, input int exp_st);
    @(posedge clock);
    #1;
    check(name, int'(bus_if.state_o), exp_st);
    check({name, "_model"}, m_state, exp_st);
  endtask

  initial begin
    int norm_exp [7] = '{1, 2, 2, 2, 6, 7, 0};
    bit norm_pv  [7] = '{1, 1, 1, 1, 0, 0, 0};
    bit norm_bsy [7] = '{1, 0, 0, 0, 1, 1, 0};
    bit norm_wen [7] = '{0, 1, 1, 1, 1, 0, 0};

    idle();
    #2 resetn = 1'b0;
    repeat (2) @(posedge clock);
    #3 resetn = 1'b1;
    @(posedge clock);
    #1;
    check("rst_state_o", int'(bus_if.state_o), 0);
    check("rst_detect_add", int'(bus_if.detect_add), 1);
    check("rst_busy", int'(bus_if.busy), 0);
    check("rst_timeout", int'(bus_if.timeout), 0);
    cmp_en = 1'b1;

    // Normal packet to FIFO 1.
    for (int i = 0; i < 7; i++) begin
      drive(norm_pv[i], 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      step("normal", norm_exp[i]);
      check("normal_busy", int'(bus_if.busy), int'(norm_bsy[i]));
      check("normal_wen", int'(bus_if.write_enb_reg), int'(norm_wen[i]));
    end

    // FIFO full in the middle of the payload.
    drive(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    step("full_lfd", 1);
    step("full_ld", 2);
    drive(1'b1, 2'd1, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    step("full_ffs", 4);
    check("full_busy", int'(bus_if.busy), 1);
    check("full_wen", int'(bus_if.write_enb_reg), 0);
    drive(1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1);
    step("full_laf", 5);
    step("full_lp", 6);
    idle();
    step("full_cpe", 7);
    step("full_da", 0);

    // Invalid header address is dropped.
    drive(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("invalid", 0);
      check("invalid_busy", int'(bus_if.busy), 0);
    end

    // Wait-till-empty; only the selected FIFO's soft reset matters.
    drive(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
    step("wte_enter", 3);
    drive(1'b0, 2'd2, 1'b0, 3'b011, 3'b001, 1'b0, 1'b0);
    step("wte_soft0", 3);
    drive(1'b0, 2'd2, 1'b0, 3'b011, 3'b100, 1'b0, 1'b0);
    step("wte_soft2", 0);

    // Watchdog on a FIFO that never drains.
    drive(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
    step("wd_enter", 3);
    drive(1'b0, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
`ifdef ROUTER_FSM_WATCHDOG_EN
      step("wd_hold", (i == 3) ? 0 : 3);
      check("wd_timeout", int'(bus_if.timeout), int'(i == 3));
`else
      step("wd_hold", 3);
      check("wd_timeout", int'(bus_if.timeout), 0);
`endif
    end
`ifdef ROUTER_FSM_WATCHDOG_EN
    step("wd_after", 0);
    check("wd_pulse_end", int'(bus_if.timeout), 0);
`endif
    idle();
    repeat (6) @(posedge clock);
    #1;

    // Asynchronous reset while loading payload.
    drive(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    step("arst_lfd", 1);
    step("arst_ld", 2);
    #2 resetn = 1'b0;
    #1;
    check("arst_state_o", int'(bus_if.state_o), 0);
    check("arst_detect_add", int'(bus_if.detect_add), 1);
    check("arst_busy", int'(bus_if.busy), 0);
    check("arst_wen", int'(bus_if.write_enb_reg), 0);
    idle();
    @(posedge clock);
    #3 resetn = 1'b1;
    @(posedge clock);
    #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit [2:0] sft;
      sft[0] = ($urandom_range(0, 19) == 0);
      sft[1] = ($urandom_range(0, 19) == 0);
      sft[2] = ($urandom_range(0, 19) == 0);
      drive(($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)), sft,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
      @(posedge clock);
      #1;
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fsm_ctrl.md
Name: router_fsm_ctrl

Overview:
Control state machine for the 1x3 router. It sequences the router register datapath (header capture, payload load, parity load/check), gates FIFO writes and backpressure (busy) toward the source, and recovers on destination soft reset. It sits between the input port, the synchronizer (FIFO status, soft resets) and the register block.

Parameters:
WAIT_LIMIT, 30, cycles allowed in WAIT_TILL_EMPTY before watchdog abort (1..65535; used only with watchdog enabled)
ADDR_INVALID, 2'b11, header address value that is dropped

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
pkt_valid  input  1  source packet valid
data_in  input  2  header address bits [1:0]
fifo_full  input  1  selected destination FIFO full
fifo_empty_0  input  1  FIFO 0 empty
fifo_empty_1  input  1  FIFO 1 empty
fifo_empty_2  input  1  FIFO 2 empty
soft_reset_0  input  1  FIFO 0 read-timeout soft reset
soft_reset_1  input  1  FIFO 1 soft reset
soft_reset_2  input  1  FIFO 2 soft reset
parity_done  input  1  register block parity captured
low_packet_valid  input  1  register block saw pkt_valid fall
detect_add  output  1  in DECODE_ADDRESS
lfd_state  output  1  in LOAD_FIRST_DATA
ld_state  output  1  in LOAD_DATA
laf_state  output  1  in LOAD_AFTER_FULL
full_state  output  1  in FIFO_FULL_STATE
rst_int_reg  output  1  in CHECK_PARITY_ERROR
write_enb_reg  output  1  FIFO write enable
busy  output  1  stall source
state_o  output  3  current state encoding (debug)
timeout  output  1  watchdog abort pulse

Behaviour:
- Encoding: DA=0, LFD=1, LD=2, WTE=3, FFS=4, LAF=5, LP=6, CPE=7. Single state register; resetn low asynchronously forces DA, addr_q=0, counter=0, timeout=0.
- Moore outputs decoded from state: detect_add=DA; lfd_state=LFD; ld_state=LD; laf_state=LAF; full_state=FFS; rst_int_reg=CPE; write_enb_reg=LD|LAF|LP; busy=all states except DA and LD. Reset values: detect_add=1, state_o=0, all other outputs 0.
- addr_q: loads data_in in DA when pkt_valid and data_in!=ADDR_INVALID; held otherwise. empty_sel/soft_sel = fifo_empty_/soft_reset_ indexed by addr_q (in DA use data_in for empty check).
- Transitions:
  DA: pkt_valid & addr valid & empty(data_in) -> LFD; pkt_valid & addr valid & !empty -> WTE; else DA (addr 3 dropped, stays DA).
  LFD -> LD.
  LD: fifo_full -> FFS; else !pkt_valid -> LP; else LD.
  FFS: fifo_full -> FFS; else LAF.
  LAF: parity_done -> DA; else low_packet_valid -> LP; else LD.
  LP -> CPE.
  CPE: fifo_full -> FFS; else DA.
  WTE: empty_sel -> LFD; else WTE.
- Soft reset priority: soft_sel high in any state except DA forces DA next cycle, overriding all transitions. Soft resets of non-selected FIFOs ignored.
- fifo_full and pkt_valid same cycle in LD: FFS wins.

Optional Feature:
ROUTER_FSM_WATCHDOG_EN: 16-bit counter increments each cycle in WTE, clears on any other state. When counter reaches WAIT_LIMIT-1 and empty_sel still low, next state DA and timeout registered high for exactly one cycle. empty_sel or soft reset on the limit cycle take priority (LFD / DA, no timeout). Without macro: no counter, WTE waits indefinitely, timeout tied 0.

Test Plan:
- Reset: assert resetn=0 mid-LD -> state_o=0 immediately, detect_add=1, busy=0, write_enb_reg=0.
- Normal packet: header addr=1, fifo_empty_1=1, 3 payload beats then pkt_valid=0 -> state_o 0,1,2,2,2,6,7,0; write_enb_reg high in LD/LP, busy high in LFD/LP/CPE.
- Full mid-payload: fifo_full=1 in LD -> FFS (state_o=4, busy=1, write_enb_reg=0); release -> LAF; with parity_done=0, low_packet_valid=1 -> LP then CPE.
- Invalid address: pkt_valid=1, data_in=2'b11 for 5 cycles -> remains DA, busy=0.
- Wait/soft reset: addr=2, fifo_empty_2=0 -> WTE (state_o=3); soft_reset_0 pulse -> stays WTE; soft_reset_2 pulse -> DA next cycle.
- Watchdog (macro on, WAIT_LIMIT=4): hold fifo_empty_2=0 in WTE -> after 4 WTE cycles state_o=0, timeout high one cycle; macro off -> stays WTE, timeout=0.
